// File: rtl/lcd_resp_pkg.sv
// Shared widths, state encoding, opcode masks and DDRAM address helpers
// for the HD44780-style LCD bus responder.
package lcd_resp_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned IDX_W        = 5;
    localparam int unsigned VISIBLE_COLS = 16;
    localparam int unsigned MIRROR_DEPTH = 2 * VISIBLE_COLS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    localparam logic [ADDR_W-1:0] LINE1_BASE = 7'h00;
    localparam logic [ADDR_W-1:0] LINE1_END  = 7'h27;
    localparam logic [ADDR_W-1:0] LINE2_BASE = 7'h40;
    localparam logic [ADDR_W-1:0] LINE2_END  = 7'h67;
    localparam logic [DATA_W-1:0] BLANK_CHAR = 8'h20;

    // Instruction class is selected by the highest set bit of the byte.
    localparam logic [DATA_W-1:0] OP_CLEAR   = 8'h01;
    localparam logic [DATA_W-1:0] OP_HOME    = 8'h02;
    localparam logic [DATA_W-1:0] OP_ENTRY   = 8'h04;
    localparam logic [DATA_W-1:0] OP_DISPLAY = 8'h08;
    localparam logic [DATA_W-1:0] OP_SHIFT   = 8'h10;
    localparam logic [DATA_W-1:0] OP_FUNC    = 8'h20;
    localparam logic [DATA_W-1:0] OP_CGRAM   = 8'h40;
    localparam logic [DATA_W-1:0] OP_DDRAM   = 8'h80;

    localparam int unsigned ENTRY_ID_BIT  = 1;
    localparam int unsigned DISPLAY_D_BIT = 2;
    localparam int unsigned FUNC_N_BIT    = 3;

    typedef struct packed {
        logic              rs;
        logic              rw;
        logic [DATA_W-1:0] data;
    } lcd_xfer_t;

    // Address counter step with the HD44780 line wrap points.
    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] addr,
                                                    input logic              inc);
        logic [ADDR_W-1:0] nxt;
        if (inc) begin
            if (addr == LINE1_END)      nxt = LINE2_BASE;
            else if (addr == LINE2_END) nxt = LINE1_BASE;
            else                        nxt = addr + 7'd1;
        end else begin
            if (addr == LINE2_BASE)     nxt = LINE1_END;
            else if (addr == LINE1_BASE) nxt = LINE2_END;
            else                        nxt = addr - 7'd1;
        end
        return nxt;
    endfunction

    // Returns {hit, mirror_index}; hit only for the visible 16 columns of each line.
    function automatic logic [IDX_W:0] addr_to_index(input logic [ADDR_W-1:0] addr);
        logic [IDX_W:0] r;
        r = '0;
        if (addr[6:4] == LINE1_BASE[6:4]) r = {1'b1, 1'b0, addr[3:0]};
        else if (addr[6:4] == LINE2_BASE[6:4]) r = {1'b1, 1'b1, addr[3:0]};
        return r;
    endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// LCD write-bus bundle between an LCD driver (master) and the responder (slave).
// Defining LCD_RESP_BUSY_READ_EN adds the busy/address read-back lines.
interface lcd_bus_responder_if;
    import lcd_resp_pkg::*;

    logic [DATA_W-1:0] lcd_data;
    logic              lcd_rw;
    logic              lcd_en;
    logic              lcd_rs;

`ifdef LCD_RESP_BUSY_READ_EN
    logic [DATA_W-1:0] lcd_dout;
    logic              lcd_dout_oe;

    modport master (output lcd_data, lcd_rw, lcd_en, lcd_rs, input lcd_dout, lcd_dout_oe);
    modport slave  (input lcd_data, lcd_rw, lcd_en, lcd_rs, output lcd_dout, lcd_dout_oe);
`else
    modport master (output lcd_data, lcd_rw, lcd_en, lcd_rs);
    modport slave  (input lcd_data, lcd_rw, lcd_en, lcd_rs);
`endif
endinterface

// File: rtl/lcd_en_strobe.sv
// Enable-strobe front end: captures the bus while lcd_en is high and classifies
// each falling edge as a valid strobe or a too-short pulse.
module lcd_en_strobe
    import lcd_resp_pkg::*;
#(
    parameter int unsigned MIN_EN_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lcd_en,
    input  logic              lcd_rs,
    input  logic              lcd_rw,
    input  logic [DATA_W-1:0] lcd_data,
    output logic              strobe,
    output logic              short_err,
    output logic              rs,
    output logic              rw,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned WIDTH_W = $clog2(MIN_EN_CYCLES + 1);

    logic               en_q;
    logic [WIDTH_W-1:0] width;
    lcd_xfer_t          xfer;
    logic               fall;

    assign fall = en_q && !lcd_en;

    // Width counter saturates at the threshold; only "long enough" matters.
    always_ff @(posedge clock) begin
        if (reset) begin
            en_q      <= 1'b0;
            width     <= '0;
            xfer      <= '0;
            strobe    <= 1'b0;
            short_err <= 1'b0;
        end else begin
            en_q      <= lcd_en;
            strobe    <= fall && (width >= WIDTH_W'(MIN_EN_CYCLES));
            short_err <= fall && (width <  WIDTH_W'(MIN_EN_CYCLES));
            if (lcd_en) begin
                if (width != WIDTH_W'(MIN_EN_CYCLES)) width <= width + WIDTH_W'(1);
                xfer <= '{rs: lcd_rs, rw: lcd_rw, data: lcd_data};
            end else begin
                width <= '0;
            end
        end
    end

    assign rs   = xfer.rs;
    assign rw   = xfer.rw;
    assign data = xfer.data;

endmodule

// File: rtl/lcd_bus_responder.sv
// Bus-side HD44780-style controller model: decodes LCD bus strobes, keeps a 2x16
// DDRAM mirror and enforces busy timing. LCD_RESP_BUSY_READ_EN enables status reads.
module lcd_bus_responder
    import lcd_resp_pkg::*;
#(
    parameter int unsigned MIN_EN_CYCLES     = 4,
    parameter int unsigned BUSY_CYCLES       = 64,
    parameter int unsigned CLEAR_BUSY_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    lcd_bus_responder_if.slave lcd,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_char,
    output logic              busy,
    output logic [ADDR_W-1:0] ddram_addr,
    output logic              display_on,
    output logic              two_line,
    output logic              cmd_valid,
    output logic [DATA_W-1:0] cmd_byte,
    output logic              err_pulse
);

    localparam int unsigned MAX_BUSY = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ?
                                       CLEAR_BUSY_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W    = (MAX_BUSY > 1) ? $clog2(MAX_BUSY) : 1;

    logic              st_strobe, st_short, st_rs, st_rw;
    logic [DATA_W-1:0] st_data;

    lcd_en_strobe #(.MIN_EN_CYCLES(MIN_EN_CYCLES)) u_strobe (
        .clock     (clock),
        .reset     (reset),
        .lcd_en    (lcd.lcd_en),
        .lcd_rs    (lcd.lcd_rs),
        .lcd_rw    (lcd.lcd_rw),
        .lcd_data  (lcd.lcd_data),
        .strobe    (st_strobe),
        .short_err (st_short),
        .rs        (st_rs),
        .rw        (st_rw),
        .data      (st_data)
    );

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  clr_idx, clr_idx_d;
    logic              inc_mode, inc_d;
    logic              cmd_rs, cmd_rs_d;
    logic              busy_d, display_on_d, two_line_d, cmd_valid_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] cmd_byte_d;
    logic              accept, status_read;
    logic [IDX_W:0]    map;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mirror [MIRROR_DEPTH];

    // Next-state, register updates and mirror write request.
    always_comb begin
        state_d      = state;
        busy_d       = busy;
        cnt_d        = cnt;
        clr_idx_d    = clr_idx;
        addr_d       = ddram_addr;
        inc_d        = inc_mode;
        display_on_d = display_on;
        two_line_d   = two_line;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte;
        cmd_rs_d     = cmd_rs;
        mem_we       = 1'b0;
        mem_idx      = '0;
        mem_wdata    = BLANK_CHAR;
        map          = addr_to_index(ddram_addr);
        status_read  = 1'b0;
`ifdef LCD_RESP_BUSY_READ_EN
        status_read  = st_rw && !st_rs;
`endif
        accept       = st_strobe && !st_rw && (state == ST_IDLE);
        err_d        = st_short || (st_strobe && !accept && !status_read);

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_EXEC;
                    cmd_valid_d = 1'b1;
                    cmd_byte_d  = st_data;
                    cmd_rs_d    = st_rs;
                end
            end
            ST_EXEC: begin
                state_d = ST_BUSY;
                cnt_d   = CNT_W'(BUSY_CYCLES - 1);
                if (cmd_rs) begin
                    mem_we    = map[IDX_W];
                    mem_idx   = map[IDX_W-1:0];
                    mem_wdata = cmd_byte;
                    addr_d    = addr_step(ddram_addr, inc_mode);
                end else if (|(cmd_byte & OP_DDRAM)) begin
                    addr_d = cmd_byte[ADDR_W-1:0];
                end else if (|(cmd_byte & OP_CGRAM)) begin
                    // no CGRAM mirror: accepted and ignored
                end else if (|(cmd_byte & OP_FUNC)) begin
                    two_line_d = cmd_byte[FUNC_N_BIT];
                end else if (|(cmd_byte & OP_SHIFT)) begin
                    // cursor/display shift has no effect on the mirror
                end else if (|(cmd_byte & OP_DISPLAY)) begin
                    display_on_d = cmd_byte[DISPLAY_D_BIT];
                end else if (|(cmd_byte & OP_ENTRY)) begin
                    inc_d = cmd_byte[ENTRY_ID_BIT];
                end else if (|(cmd_byte & OP_HOME)) begin
                    addr_d = '0;
                end else if (|(cmd_byte & OP_CLEAR)) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = clr_idx;
                addr_d    = '0;
                inc_d     = 1'b1;
                clr_idx_d = clr_idx + IDX_W'(1);
                if (clr_idx == IDX_W'(MIRROR_DEPTH - 1)) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(CLEAR_BUSY_CYCLES - 1);
                end
            end
            default: begin
                if (cnt == '0) state_d = ST_IDLE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            clr_idx    <= '0;
            ddram_addr <= '0;
            inc_mode   <= 1'b1;
            display_on <= 1'b0;
            two_line   <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            cmd_rs     <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_d;
            busy       <= busy_d;
            cnt        <= cnt_d;
            clr_idx    <= clr_idx_d;
            ddram_addr <= addr_d;
            inc_mode   <= inc_d;
            display_on <= display_on_d;
            two_line   <= two_line_d;
            cmd_valid  <= cmd_valid_d;
            cmd_byte   <= cmd_byte_d;
            cmd_rs     <= cmd_rs_d;
            err_pulse  <= err_d;
        end
    end

    // Mirror and read port; a same-cycle write and read returns the old entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < MIRROR_DEPTH; i++) mirror[i] <= BLANK_CHAR;
            rd_char <= BLANK_CHAR;
        end else begin
            if (mem_we) mirror[mem_idx] <= mem_wdata;
            rd_char <= mirror[rd_addr];
        end
    end

`ifdef LCD_RESP_BUSY_READ_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            lcd.lcd_dout    <= '0;
            lcd.lcd_dout_oe <= 1'b0;
        end else begin
            lcd.lcd_dout    <= {busy, ddram_addr};
            lcd.lcd_dout_oe <= lcd.lcd_en && lcd.lcd_rw;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized self-checking bench for lcd_bus_responder against a
// transaction-level model of the display controller.
module tb_lcd_bus_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_char;
    logic       busy;
    logic [6:0] ddram_addr;
    logic       display_on, two_line, cmd_valid, err_pulse;
    logic [7:0] cmd_byte;

    lcd_bus_responder_if lcd ();

    lcd_bus_responder dut (
        .clock      (clock),
        .reset      (reset),
        .lcd        (lcd),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .busy       (busy),
        .ddram_addr (ddram_addr),
        .display_on (display_on),
        .two_line   (two_line),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .err_pulse  (err_pulse)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [7:0] m_mem [32];
    logic [6:0] m_addr;
    bit         m_inc, m_disp, m_two;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_addr = 7'h00; m_inc = 1'b1; m_disp = 1'b0; m_two = 1'b0;
    endtask

    function automatic logic [6:0] m_next(input logic [6:0] a, input bit inc);
        int v;
        v = int'(a);
        if (inc) v = (v == 'h27) ? 'h40 : (v == 'h67) ? 0 : (v + 1) % 128;
        else     v = (v == 'h40) ? 'h27 : (v == 0) ? 'h67 : (v + 127) % 128;
        return 7'(v);
    endfunction

    task automatic m_apply(input logic rs, input logic [7:0] b);
        int v;
        int a;
        v = int'(b);
        a = int'(m_addr);
        if (rs) begin
            if (a < 16) m_mem[a] = b;
            else if (a >= 64 && a < 80) m_mem[a - 48] = b;
            m_addr = m_next(m_addr, m_inc);
        end else if (v >= 128) m_addr = 7'(v - 128);
        else if (v >= 64) begin end
        else if (v >= 32) m_two = b[3];
        else if (v >= 16) begin end
        else if (v >= 8)  m_disp = b[2];
        else if (v >= 4)  m_inc = b[1];
        else if (v >= 2)  m_addr = 7'h00;
        else if (v == 1) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_addr = 7'h00; m_inc = 1'b1;
        end
    endtask

    task automatic drive_strobe(input logic rs, input logic rw, input logic [7:0] b, input int width);
        @(posedge clock); #1;
        lcd.lcd_rs = rs; lcd.lcd_rw = rw; lcd.lcd_data = b; lcd.lcd_en = 1'b1;
        repeat (width) @(posedge clock);
        #1 lcd.lcd_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000 && busy; t++) @(negedge clock);
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic start_cmd(input logic rs, input logic [7:0] b, input int width, output bit seen);
        wait_idle();
        drive_strobe(rs, 1'b0, b, width);
        seen = 1'b0;
        for (int t = 0; t < 8 && !seen; t++) begin
            @(negedge clock);
            if (cmd_valid) seen = 1'b1;
        end
        check("cmd_valid", 32'(seen), 1);
        if (seen) check("cmd_byte", cmd_byte, b);
    endtask

    task automatic send(input logic rs, input logic [7:0] b, input int width);
        bit seen;
        int len, exp_len;
        start_cmd(rs, b, width, seen);
        exp_len = (!rs && b == 8'h01) ? (1 + 32 + 1024) : (1 + 64);
        len = 0;
        while (busy && len < 3000) begin
            len++;
            @(negedge clock);
            if (len == 1) check("cmd_valid_pulse", cmd_valid, 1'b0);
        end
        m_apply(rs, b);
        if (seen) check("busy_len", len, exp_len);
        check("ddram_addr", ddram_addr, m_addr);
        check("display_on", display_on, m_disp);
        check("two_line", two_line, m_two);
    endtask

    task automatic strobe_expect(input string tag, input logic rs, input logic rw,
                                 input logic [7:0] b, input int width, input int exp_err);
        int errs, cv;
        errs = 0; cv = 0;
        drive_strobe(rs, rw, b, width);
        repeat (8) begin
            @(negedge clock);
            errs += int'(err_pulse);
            cv   += int'(cmd_valid);
        end
        check({tag, "_err_cycles"}, errs, exp_err);
        check({tag, "_no_cmd"}, cv, 0);
    endtask

    task automatic read_check(input int idx);
        rd_addr = 5'(idx);
        @(negedge clock);
        check($sformatf("rd_char[%0d]", idx), rd_char, m_mem[idx]);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) read_check(i);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [6:0] a;
        lcd.lcd_en = 1'b0; lcd.lcd_rs = 1'b0; lcd.lcd_rw = 1'b0; lcd.lcd_data = 8'h00;
        m_reset();
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_ddram_addr", ddram_addr, 7'h00);
        check("rst_display_on", display_on, 1'b0);
        check("rst_two_line", two_line, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_byte", cmd_byte, 8'h00);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_rd_char", rd_char, 8'h20);
        reset = 1'b0;
        @(negedge clock);

        // Power-on style initialisation, then first character
        send(0, 8'h38, 17); send(0, 8'h0C, 17); send(0, 8'h01, 17);
        send(0, 8'h06, 17); send(0, 8'h80, 17); send(1, 8'h61, 17);
        read_check(0);

        send(0, 8'hC0, 17); send(1, 8'h41, 17);
        read_check(16);

        // Off-screen address: byte discarded, counter wraps into line 2
        send(0, 8'hA7, 17); send(1, 8'h5A, 17); send(1, 8'h42, 17);
        read_check(16);
        read_all();

        // Decrement from 0x00 wraps to 0x67
        send(0, 8'h04, 17); send(0, 8'h80, 17); send(1, 8'h33, 17);
        read_check(0);

        // Strobe while busy is rejected without side effects
        start_cmd(0, 8'h85, 17, seen);
        m_apply(0, 8'h85);
        repeat (10) @(negedge clock);
        strobe_expect("busy_strobe", 1, 0, 8'h77, 17, 1);
        wait_idle();
        check("busy_strobe_addr", ddram_addr, m_addr);
        read_all();

        // Enable width boundary
        strobe_expect("short_2", 1, 0, 8'h55, 2, 1);
        strobe_expect("short_3", 1, 0, 8'h55, 3, 1);
        send(1, 8'h4D, 4);
        read_all();

`ifdef LCD_RESP_BUSY_READ_EN
        strobe_expect("status_read", 0, 1, 8'h00, 17, 0);
        strobe_expect("data_read", 1, 1, 8'h00, 17, 1);
`else
        strobe_expect("read_strobe", 0, 1, 8'h00, 17, 1);
`endif
        check("read_strobe_addr", ddram_addr, m_addr);

        // Randomized instruction/data mix
        send(0, 8'h06, 17);
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0, 1, 2: send(1, 8'($urandom_range(8'h21, 8'h7E)), $urandom_range(4, 20));
                3: begin
                    case ($urandom_range(0, 7))
                        0: a = 7'h0F; 1: a = 7'h27; 2: a = 7'h40; 3: a = 7'h4F;
                        4: a = 7'h67; 5: a = 7'h00; 6: a = 7'h26;
                        default: a = 7'($urandom_range(0, 127));
                    endcase
                    send(0, 8'h80 | 8'(a), 17);
                end
                4: send(0, 8'h04 | 8'($urandom_range(0, 3)), $urandom_range(4, 20));
                5: send(0, 8'h08 | 8'($urandom_range(0, 7)), 17);
                default: send(0, 8'h20 | 8'($urandom_range(0, 15)), 17);
            endcase
        end
        read_all();

        // Fill every visible cell, then clear
        send(0, 8'h06, 17);
        send(0, 8'h80, 17);
        for (int i = 0; i < 16; i++) send(1, 8'(8'h41 + i), 17);
        send(0, 8'hC0, 17);
        for (int i = 0; i < 16; i++) send(1, 8'(8'h61 + i), 17);
        read_all();
        send(0, 8'h01, 17);
        read_all();

        // Reset in the middle of a clear
        send(0, 8'h05, 17); send(0, 8'h28, 17); send(0, 8'h0C, 17);
        send(0, 8'h83, 17); send(1, 8'h58, 17); send(1, 8'h59, 17);
        start_cmd(0, 8'h01, 17, seen);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        m_reset();
        check("midclr_busy", busy, 1'b0);
        check("midclr_ddram_addr", ddram_addr, 7'h00);
        check("midclr_display_on", display_on, 1'b0);
        check("midclr_two_line", two_line, 1'b0);
        check("midclr_cmd_valid", cmd_valid, 1'b0);
        check("midclr_rd_char", rd_char, 8'h20);
        reset = 1'b0;
        @(negedge clock);
        read_all();
        send(1, 8'h4B, 17);
        read_check(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
